// File: rtl/alu_pkg.sv
// Shared constants for the ALU homework datapath: sequencer state encoding
// and the default operand width.
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ALU_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, bo is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, sharing one full_subtractor cell.
// Optional signed-overflow output enabled with `define SERIAL_SUB_OVF_EN.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             brw;
    logic             bit_d, bit_bo;
    logic             last_bit;
    logic             accept;

    full_subtractor u_fs (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .bi (brw),
        .d  (bit_d),
        .bo (bit_bo)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // start is only honoured between operations; in RUN it is ignored.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a <= '0;
            sh_b <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            sh_a <= a;
            sh_b <= b;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            sh_a <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b <= {1'b0, sh_b[WIDTH-1:1]};
            brw  <= bit_bo;
            cnt  <= cnt + 1'b1;
            // Result bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
            diff <= {bit_d, diff[WIDTH-1:1]};
            if (last_bit) bout <= bit_bo;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if ((state == ST_RUN) && last_bit) begin
            // bit_d is the MSB of the difference on the final step.
            ovf <= (a_msb != b_msb) && (bit_d != a_msb);
        end
    end
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor with borrow: computes diff = a - b - bin, LSB first, one bit per clock. It is the inverse datapath of the ripple full adder and sits beside it in the ALU homework datapath. Uses a start/busy/done handshake so the sequencing logic can share one full-subtractor cell across all bit positions.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  borrow-in, captured when start is accepted
diff  output  WIDTH  result; valid while done=1 and held until next accepted start
bout  output  1  borrow-out of the MSB stage; same validity as diff
busy  output  1  high while operation in progress
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async assert, rst=1): state=IDLE; diff=0, bout=0, busy=0, done=0; operand shift registers, bit counter and borrow flop cleared. Applies immediately, including mid-operation; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, bin into shift registers; counter=0; go to RUN.
  - RUN: each edge processes bit i = counter.
    - d_i = a_i ^ b_i ^ brw.
    - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
    - d_i is shifted into diff from the MSB side.
    - Counter increments; after bit WIDTH-1 go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 -> capture new operands, go to RUN. Otherwise go to IDLE.
- Latency:
  - start accepted on edge k.
  - busy=1 from after edge k through after edge k+WIDTH-1.
  - After edge k+WIDTH: done=1, busy=0, diff/bout final.
  - Result is WIDTH+1 cycles after acceptance.
- start while in RUN is ignored (no queueing); operands may change freely during RUN.
- diff/bout stay stable from DONE until the next accepted start. Intermediate bits are visible on diff during RUN but are not valid.
- Arithmetic: unsigned modulo 2^WIDTH.
  - bout=1 iff a < b + bin, as unsigned values.
  - Signed interpretation: diff is the two's-complement difference truncated to WIDTH bits.
- busy and done are never high together.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), signed overflow.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
  - ovf is registered, reset 0, and has the same validity/hold rules as diff.
- Undefined: ovf port and its logic are absent; all other behaviour identical.

Decomposition:
- Shared package alu_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant ALU_WIDTH=4.
- Sub-module full_subtractor (combinational):
  - inputs x, y, bi;
  - outputs d, bo;
  - equations as above.
- One instance in serial_subtractor; counter width is $clog2(WIDTH)+1.

Test Plan:
- 0 - 0 with bin=0 -> done after 5 cycles; diff=0000, bout=0, ovf=0.
- a=0111, b=0011, bin=0 -> diff=0100, bout=0; busy high 4 cycles, then done pulse 1 cycle.
- a=0011, b=0100, bin=0 -> diff=1111, bout=1; also a=0101, b=0101, bin=1 -> diff=1111, bout=1.
- Back-to-back: start held high in DONE with a=1111, b=0001 -> new RUN begins with no IDLE cycle; diff=1110, bout=0. A second start pulse during that RUN is ignored (exactly one done).
- Reset mid-op: assert rst after 2 RUN cycles -> all outputs 0 immediately. After release, start with a=1000, b=0001 -> diff=0111, bout=0.
- With SERIAL_SUB_OVF_EN:
  - a=1000, b=0001 -> ovf=1;
  - a=0111, b=1111 -> diff=1000, bout=1, ovf=1;
  - a=0100, b=0001 -> ovf=0.
